// File: rtl/sprite_vblank_commit_queue_if.sv
// Bus-side write channel for the sprite vblank commit queue.
// The bus decode (master) offers {addr,data} entries; the queue (slave) answers with ready.
interface sprite_vblank_commit_queue_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sprite_vblank_commit_queue.sv
// Sprite vblank commit queue: buffers CPU register writes and replays them onto the sprite
// register bank only while drain_ok (vblank, or streaming off), one entry per cycle.
// Optional feature macro: SPRITE_COMMIT_COALESCE_EN -- a write to the same address as the
// newest queued entry overwrites that entry's data instead of allocating a new slot.
module sprite_vblank_commit_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sprite_vblank_commit_queue_if.slave wr,
    input  logic                     stream_en,
    input  logic                     vblank,
    output logic                     cfg_we,
    output logic [ADDR_W-1:0]        cfg_addr,
    output logic [DATA_W-1:0]        cfg_data,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     commit_done
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              cfg_we_q, cfg_we_d;
    logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
    logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
    logic              commit_done_q, commit_done_d;

    logic              drain_ok;
    logic              not_empty;
    logic              not_full;
    logic              pop;
    logic              push;
    logic              coal_hit;
    logic              coal_wr;
    logic [PTR_W-1:0]  newest_idx;

    assign drain_ok   = !stream_en || vblank;
    assign not_empty  = (count_q != '0);
    assign not_full   = (count_q != CNT_W'(DEPTH));
    // Pop uses pre-edge occupancy, so a push into an empty queue never pops in the same cycle.
    assign pop        = drain_ok && not_empty;
    assign newest_idx = wr_ptr_q - PTR_W'(1);

`ifdef SPRITE_COMMIT_COALESCE_EN
    // Newest entry can absorb the write unless it is the very entry leaving this cycle.
    assign coal_hit = not_empty && (addr_mem_q[newest_idx] == wr.wr_addr) &&
                      ((count_q >= CNT_W'(2)) || !pop);
`else
    assign coal_hit = 1'b0;
`endif

    assign wr.wr_ready = not_full || coal_hit;
    assign coal_wr     = wr.wr_valid && coal_hit;
    assign push        = wr.wr_valid && wr.wr_ready && !coal_hit;

    // Next-state for occupancy, overflow flag, register-bank write port and completion pulse.
    always_comb begin
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        overflow_d    = overflow_q;
        cfg_we_d      = 1'b0;
        cfg_addr_d    = cfg_addr_q;
        cfg_data_d    = cfg_data_q;
        commit_done_d = 1'b0;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end else if (wr.wr_valid && !wr.wr_ready) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            cfg_we_d   = 1'b1;
            cfg_addr_d = addr_mem_q[rd_ptr_q];
            cfg_data_d = data_mem_q[rd_ptr_q];
        end
        commit_done_d = pop && (count_q == CNT_W'(1)) && stream_en && !push;
    end

    // Drain FSM next-state; tracks whether queued entries are waiting or flowing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (push) begin
                    state_d = drain_ok ? StDrain : StHold;
                end
            end
            StHold: begin
                if (count_d == '0) begin
                    state_d = StIdle;
                end else if (drain_ok) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (count_d == '0) begin
                    state_d = StIdle;
                end else if (!drain_ok) begin
                    state_d = StHold;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, pointers and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            cfg_we_q      <= 1'b0;
            cfg_addr_q    <= '0;
            cfg_data_q    <= '0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            cfg_we_q      <= cfg_we_d;
            cfg_addr_q    <= cfg_addr_d;
            cfg_data_q    <= cfg_data_d;
            commit_done_q <= commit_done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= wr.wr_addr;
            data_mem_q[wr_ptr_q] <= wr.wr_data;
        end else if (coal_wr) begin
            data_mem_q[newest_idx] <= wr.wr_data;
        end
    end

    assign cfg_we      = cfg_we_q;
    assign cfg_addr    = cfg_addr_q;
    assign cfg_data    = cfg_data_q;
    assign pending     = count_q;
    assign overflow    = overflow_q;
    assign commit_done = commit_done_q;
endmodule
